// File: rtl/id_exe_mem_dest_tracker_pkg.sv
// Shared types for the EXE/MEM destination tracker.
// Slot layout, bubble value and bubble-cause encodings.
`ifndef REG_FILE_ADDRESS_LEN
`define REG_FILE_ADDRESS_LEN 4
`endif

package id_exe_mem_dest_tracker_pkg;

  localparam int REG_ADDR_W = `REG_FILE_ADDRESS_LEN;

  typedef enum logic [1:0] {
    STATE_RUN     = 2'd0,
    STATE_HAZ     = 2'd1,
    STATE_MEMWAIT = 2'd2,
    STATE_FLUSH   = 2'd3
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
    logic                  mem_read;
  } slot_t;

  localparam slot_t BUBBLE = '{
    dest:     '0,
    wb_en:    1'b0,
    mem_read: 1'b0
  };

endpackage

// File: rtl/id_exe_mem_dest_tracker_if.sv
// Bundle between the ID/hazard side and the tracker.
// The pipeline side drives the master end.
interface id_exe_mem_dest_tracker_if #(
  parameter int ADDR_W =
    id_exe_mem_dest_tracker_pkg::REG_ADDR_W,
  parameter int CNT_W = 16
);

  logic              id_valid;
  logic [ADDR_W-1:0] id_dest;
  logic              id_wb_en;
  logic              id_mem_read;
  logic              hazard;
  logic              branch_taken;
  logic              mem_ready;

  logic [ADDR_W-1:0] exe_wb_dest;
  logic              exe_wb_enable;
  logic              EXE_mem_read_en;
  logic [ADDR_W-1:0] mem_wb_dest;
  logic              mem_wb_enable;
  logic              freeze_if;
  logic              flush_if_id;
  logic [1:0]        state;
  logic [CNT_W-1:0]  hazard_stalls;
  logic [CNT_W-1:0]  mem_waits;
  logic [CNT_W-1:0]  flushes;
  logic              deadlock;

  modport master (
    output id_valid, id_dest, id_wb_en,
    output id_mem_read, hazard,
    output branch_taken, mem_ready,
    input  exe_wb_dest, exe_wb_enable,
    input  EXE_mem_read_en,
    input  mem_wb_dest, mem_wb_enable,
    input  freeze_if, flush_if_id, state,
    input  hazard_stalls, mem_waits,
    input  flushes, deadlock
  );

  modport slave (
    input  id_valid, id_dest, id_wb_en,
    input  id_mem_read, hazard,
    input  branch_taken, mem_ready,
    output exe_wb_dest, exe_wb_enable,
    output EXE_mem_read_en,
    output mem_wb_dest, mem_wb_enable,
    output freeze_if, flush_if_id, state,
    output hazard_stalls, mem_waits,
    output flushes, deadlock
  );

endinterface

// File: rtl/id_exe_mem_dest_tracker_sat_counter.sv
// Saturating up-counter for pipeline statistics.
// Holds at all-ones instead of wrapping.
module id_exe_mem_dest_tracker_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_exe_mem_dest_tracker.sv
// Tracks dest/wb/load info through EXE and MEM,
// inserts bubbles and drives freeze/flush controls.
module id_exe_mem_dest_tracker
  import id_exe_mem_dest_tracker_pkg::*;
#(
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input logic clk,
  input logic rst,
  id_exe_mem_dest_tracker_if.slave bus
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX =
    RUN_W'(MAX_STALL);

  slot_t             exe_q, exe_d;
  slot_t             mem_q, mem_d;
  slot_t             id_slot;
  state_t            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              dead_q, dead_d;
  logic              do_wait;
  logic              do_flush;
  logic              do_haz;

  assign do_wait  = ~bus.mem_ready;
  assign do_flush = bus.mem_ready
                  & bus.branch_taken;
  assign do_haz   = bus.mem_ready
                  & ~bus.branch_taken
                  & bus.hazard
                  & bus.id_valid;

  assign id_slot = '{
    dest:     bus.id_dest,
    wb_en:    bus.id_wb_en,
    mem_read: bus.id_mem_read
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q   <= BUBBLE;
      mem_q   <= BUBBLE;
      state_q <= STATE_RUN;
      run_q   <= '0;
      dead_q  <= 1'b0;
    end else begin
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      state_q <= state_d;
      run_q   <= run_d;
      dead_q  <= dead_d;
    end
  end

  // Memory wait freezes everything, including the stall run.
  always_comb begin
    exe_d   = exe_q;
    mem_d   = mem_q;
    state_d = state_q;
    run_d   = run_q;
    dead_d  = dead_q;
    unique case (1'b1)
      do_wait: begin
        state_d = STATE_MEMWAIT;
      end
      do_flush: begin
        mem_d   = exe_q;
        exe_d   = BUBBLE;
        state_d = STATE_FLUSH;
        run_d   = '0;
      end
      do_haz: begin
        mem_d   = exe_q;
        exe_d   = BUBBLE;
        state_d = STATE_HAZ;
        if (run_q != RUN_MAX)
          run_d = run_q + 1'b1;
      end
      default: begin
        mem_d   = exe_q;
        exe_d   = bus.id_valid ? id_slot : BUBBLE;
        state_d = STATE_RUN;
        run_d   = '0;
      end
    endcase
    if (run_d == RUN_MAX)
      dead_d = 1'b1;
  end

  id_exe_mem_dest_tracker_sat_counter #(
    .W(CNT_W)
  ) u_haz_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (do_haz),
    .count (bus.hazard_stalls)
  );

  id_exe_mem_dest_tracker_sat_counter #(
    .W(CNT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (do_wait),
    .count (bus.mem_waits)
  );

  id_exe_mem_dest_tracker_sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (do_flush),
    .count (bus.flushes)
  );

  assign bus.exe_wb_dest     = exe_q.dest;
  assign bus.exe_wb_enable   = exe_q.wb_en;
  assign bus.EXE_mem_read_en = exe_q.mem_read;
  assign bus.mem_wb_dest     = mem_q.dest;
  assign bus.mem_wb_enable   = mem_q.wb_en;
  assign bus.state           = state_q;
  assign bus.deadlock        = dead_q;

  // A taken branch discards the stalled instruction.
  assign bus.freeze_if = ~bus.mem_ready
                       | (bus.hazard
                          & bus.id_valid
                          & ~bus.branch_taken);
  assign bus.flush_if_id = bus.branch_taken
                         & bus.mem_ready;

endmodule

// File: tb/tb_id_exe_mem_dest_tracker.sv
// Directed bench for id_exe_mem_dest_tracker.
// Hand-computed expectations per vector.
module tb_id_exe_mem_dest_tracker;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   h_cnt;

  id_exe_mem_dest_tracker_if #(
    .ADDR_W(4),
    .CNT_W (16)
  ) bus ();

  id_exe_mem_dest_tracker #(
    .ADDR_W   (4),
    .CNT_W    (16),
    .MAX_STALL(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(
    input logic       v,
    input logic [3:0] d,
    input logic       w,
    input logic       m
  );
    bus.id_valid    = v;
    bus.id_dest     = d;
    bus.id_wb_en    = w;
    bus.id_mem_read = m;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    set_id(1'b0, 4'd0, 1'b0, 1'b0);
    bus.hazard       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b1;
    #2;
    chk("rst_exe_en", bus.exe_wb_enable, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_dead", bus.deadlock, 0);
    chk("rst_freeze", bus.freeze_if, 0);
    tick();
    rst = 1'b1;

    // ID -> EXE -> MEM latency
    set_id(1'b1, 4'd3, 1'b1, 1'b1);
    tick();
    chk("lat_exe_dest", bus.exe_wb_dest, 3);
    chk("lat_exe_en", bus.exe_wb_enable, 1);
    chk("lat_exe_ld", bus.EXE_mem_read_en, 1);
    chk("lat_mem_en0", bus.mem_wb_enable, 0);
    set_id(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("lat_mem_dest", bus.mem_wb_dest, 3);
    chk("lat_mem_en", bus.mem_wb_enable, 1);
    chk("lat_exe_bub", bus.exe_wb_enable, 0);

    // load-use stall
    set_id(1'b1, 4'd1, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd2, 1'b1, 1'b0);
    bus.hazard = 1'b1;
    #1;
    chk("lu_freeze", bus.freeze_if, 1);
    chk("lu_flush", bus.flush_if_id, 0);
    tick();
    chk("lu_exe_bub", bus.exe_wb_enable, 0);
    chk("lu_exe_ld", bus.EXE_mem_read_en, 0);
    chk("lu_mem_dest", bus.mem_wb_dest, 1);
    chk("lu_stalls", bus.hazard_stalls, 1);
    chk("lu_state", bus.state, 1);
    bus.hazard = 1'b0;
    tick();
    chk("lu_exe_dest", bus.exe_wb_dest, 2);
    chk("lu_state_run", bus.state, 0);
    chk("lu_mem_bub", bus.mem_wb_enable, 0);

    // hazard without a valid ID is ignored
    set_id(1'b0, 4'd0, 1'b0, 1'b0);
    bus.hazard = 1'b1;
    #1;
    chk("hz_nv_freeze", bus.freeze_if, 0);
    tick();
    chk("hz_nv_stalls", bus.hazard_stalls, 1);
    chk("hz_nv_state", bus.state, 0);
    bus.hazard = 1'b0;

    // memory wait holds both slots
    set_id(1'b1, 4'd2, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd9, 1'b1, 1'b1);
    bus.mem_ready = 1'b0;
    #1;
    chk("mw_freeze", bus.freeze_if, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("mw_exe_dest", bus.exe_wb_dest, 7);
    chk("mw_exe_en", bus.exe_wb_enable, 1);
    chk("mw_exe_ld", bus.EXE_mem_read_en, 0);
    chk("mw_mem_dest", bus.mem_wb_dest, 2);
    chk("mw_mem_en", bus.mem_wb_enable, 1);
    chk("mw_waits", bus.mem_waits, 3);
    chk("mw_state", bus.state, 2);
    bus.mem_ready = 1'b1;

    // branch beats hazard
    bus.hazard       = 1'b1;
    bus.branch_taken = 1'b1;
    #1;
    chk("br_flush", bus.flush_if_id, 1);
    chk("br_freeze", bus.freeze_if, 0);
    tick();
    chk("br_flushes", bus.flushes, 1);
    chk("br_stalls", bus.hazard_stalls, 1);
    chk("br_exe_bub", bus.exe_wb_enable, 0);
    chk("br_mem_dest", bus.mem_wb_dest, 7);
    chk("br_state", bus.state, 3);
    bus.hazard       = 1'b0;
    bus.branch_taken = 1'b0;

    // asynchronous reset mid-stream
    set_id(1'b1, 4'd5, 1'b1, 1'b1);
    tick();
    chk("mr_pre_dest", bus.exe_wb_dest, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_exe_dest", bus.exe_wb_dest, 0);
    chk("mr_exe_en", bus.exe_wb_enable, 0);
    chk("mr_exe_ld", bus.EXE_mem_read_en, 0);
    chk("mr_mem_en", bus.mem_wb_enable, 0);
    chk("mr_mem_dest", bus.mem_wb_dest, 0);
    chk("mr_state", bus.state, 0);
    chk("mr_stalls", bus.hazard_stalls, 0);
    chk("mr_waits", bus.mem_waits, 0);
    chk("mr_flushes", bus.flushes, 0);
    #2;
    rst = 1'b1;

    // long hazard with two memory waits inserted
    bus.hazard = 1'b1;
    set_id(1'b1, 4'd4, 1'b1, 1'b0);
    h_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = !(i == 3 || i == 7);
      tick();
      if (bus.mem_ready) h_cnt++;
      if (h_cnt == 7 && bus.mem_ready)
        chk("dl_before", bus.deadlock, 0);
    end
    chk("dl_set", bus.deadlock, 1);
    chk("dl_stalls", bus.hazard_stalls, 8);
    chk("dl_waits", bus.mem_waits, 2);
    chk("dl_exe_bub", bus.exe_wb_enable, 0);
    bus.mem_ready = 1'b1;
    bus.hazard    = 1'b0;
    tick();
    chk("dl_sticky", bus.deadlock, 1);
    chk("dl_state", bus.state, 0);
    chk("dl_exe_dest", bus.exe_wb_dest, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
